// File: rtl/fsm_pkg.sv
// Shared encodings for the sequence detector and its event counter.
// Detector codes must match the upstream detector's state_out.
package fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ONE  = 2'b01,
    S_DET  = 2'b10
  } det_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_PEND = 1'b1
  } rpt_state_t;

  // 2'b11 is illegal upstream and is treated as not-detect.
  function automatic logic is_detect(input logic [1:0] s);
    return s == S_DET;
  endfunction

endpackage

// File: rtl/seq_edge_det.sv
// Rising-edge detector on the detector's S_DET state: one hit per entry into S_DET.
module seq_edge_det
  import fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state_in,
  output logic       hit
);

  logic [1:0] prev_state_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_state_reg <= S_IDLE;
    end else begin
      prev_state_reg <= state_in;
    end
  end

  assign hit = is_detect(state_in) && !is_detect(prev_state_reg);

endmodule

// File: rtl/seq_event_counter.sv
// Counts detector hits and offers the running total every THRESH hits over valid/ready.
// Define SEQ_CNT_WRAP_EN to let total wrap instead of saturating.
module seq_event_counter
  import fsm_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       state_in,
  input  logic             clear,
  output logic             hit_pulse,
  output logic [CNT_W-1:0] total,
  output logic [CNT_W-1:0] win_cnt,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_data,
  output logic             rpt_drop
);

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] TOTAL_MAX = '1;

  logic             hit;
  logic             win_done;
  logic [CNT_W-1:0] total_inc;

  logic             hit_pulse_reg, hit_pulse_next;
  logic [CNT_W-1:0] total_reg, total_next;
  logic [CNT_W-1:0] win_reg, win_next;
  logic             rpt_valid_reg, rpt_valid_next;
  logic [CNT_W-1:0] rpt_data_reg, rpt_data_next;
  logic             rpt_drop_reg, rpt_drop_next;
  rpt_state_t       rstate_reg, rstate_next;

  seq_edge_det u_edge_det (
    .clk      (clk),
    .reset    (reset),
    .state_in (state_in),
    .hit      (hit)
  );

`ifdef SEQ_CNT_WRAP_EN
  assign total_inc = total_reg + CNT_W'(1);
`else
  assign total_inc = (total_reg == TOTAL_MAX) ? total_reg : total_reg + CNT_W'(1);
`endif

  assign win_done = hit && (win_reg == WIN_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_pulse_reg <= 1'b0;
      total_reg     <= '0;
      win_reg       <= '0;
      rpt_valid_reg <= 1'b0;
      rpt_data_reg  <= '0;
      rpt_drop_reg  <= 1'b0;
      rstate_reg    <= R_IDLE;
    end else begin
      hit_pulse_reg <= hit_pulse_next;
      total_reg     <= total_next;
      win_reg       <= win_next;
      rpt_valid_reg <= rpt_valid_next;
      rpt_data_reg  <= rpt_data_next;
      rpt_drop_reg  <= rpt_drop_next;
      rstate_reg    <= rstate_next;
    end
  end

  always_comb begin
    hit_pulse_next = 1'b0;
    total_next     = total_reg;
    win_next       = win_reg;
    rpt_valid_next = rpt_valid_reg;
    rpt_data_next  = rpt_data_reg;
    rpt_drop_next  = rpt_drop_reg;
    rstate_next    = rstate_reg;

    if (clear) begin
      // Clear wins over a coincident hit; that hit is lost, not deferred.
      total_next     = '0;
      win_next       = '0;
      rpt_valid_next = 1'b0;
      rpt_data_next  = '0;
      rpt_drop_next  = 1'b0;
      rstate_next    = R_IDLE;
    end else begin
      hit_pulse_next = hit;
      if (hit) begin
        total_next = total_inc;
        win_next   = win_done ? '0 : win_reg + CNT_W'(1);
      end

      case (rstate_reg)
        R_IDLE: begin
          if (win_done) begin
            rpt_data_next  = total_inc;
            rpt_valid_next = 1'b1;
            rstate_next    = R_PEND;
          end
        end
        R_PEND: begin
          if (win_done) begin
            // A handshake on the completing edge frees the slot for the new report.
            if (rpt_ready) begin
              rpt_data_next = total_inc;
            end else begin
              rpt_drop_next = 1'b1;
            end
          end else if (rpt_ready) begin
            rpt_valid_next = 1'b0;
            rstate_next    = R_IDLE;
          end
        end
        default: rstate_next = R_IDLE;
      endcase
    end
  end

  assign hit_pulse = hit_pulse_reg;
  assign total     = total_reg;
  assign win_cnt   = win_reg;
  assign rpt_valid = rpt_valid_reg;
  assign rpt_data  = rpt_data_reg;
  assign rpt_drop  = rpt_drop_reg;

endmodule

// File: tb/tb_seq_event_counter.sv
// Self-checking bench for seq_event_counter: directed scenarios plus randomized
// traffic against a count-based reference model; a second instance covers saturation/wrap.
module tb_seq_event_counter;

  localparam int W      = 8;
  localparam int THRESH = 4;
  localparam int WB     = 3;
  localparam int TB_T   = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    state_in;
  logic          clear;
  logic          rpt_ready;
  logic          hit_pulse;
  logic [W-1:0]  total, win_cnt, rpt_data;
  logic          rpt_valid, rpt_drop;

  logic          clear_b;
  logic          hit_pulse_b;
  logic [WB-1:0] total_b, win_cnt_b, rpt_data_b;
  logic          rpt_valid_b, rpt_drop_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: hits since last clear/reset plus report bookkeeping.
  bit m_prev_det;
  int m_count;
  bit m_hit;
  bit m_pend;
  int m_data;
  bit m_drop;

  always #5 clk = ~clk;

  seq_event_counter #(.CNT_W(W), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .state_in(state_in), .clear(clear),
    .hit_pulse(hit_pulse), .total(total), .win_cnt(win_cnt),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_data(rpt_data),
    .rpt_drop(rpt_drop)
  );

  seq_event_counter #(.CNT_W(WB), .THRESH(TB_T)) dut_b (
    .clk(clk), .reset(reset), .state_in(state_in), .clear(clear_b),
    .hit_pulse(hit_pulse_b), .total(total_b), .win_cnt(win_cnt_b),
    .rpt_valid(rpt_valid_b), .rpt_ready(1'b0), .rpt_data(rpt_data_b),
    .rpt_drop(rpt_drop_b)
  );

  function automatic int exp_total(input int c);
`ifdef SEQ_CNT_WRAP_EN
    return c % (1 << W);
`else
    return (c > (1 << W) - 1) ? (1 << W) - 1 : c;
`endif
  endfunction

  task automatic model_reset();
    m_prev_det = 0; m_count = 0; m_hit = 0; m_pend = 0; m_data = 0; m_drop = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then step past the edge.
  task automatic step(input logic [1:0] st, input logic clr, input logic rdy);
    bit h;
    state_in = st; clear = clr; rpt_ready = rdy;
    h = (st == 2'b10) && !m_prev_det;
    m_prev_det = (st == 2'b10);
    if (clr) begin
      m_count = 0; m_hit = 0; m_pend = 0; m_data = 0; m_drop = 0;
    end else begin
      m_hit = h;
      if (h) m_count++;
      if (h && (m_count % THRESH == 0)) begin
        if (!m_pend || rdy) begin
          m_data = exp_total(m_count);
          m_pend = 1;
        end else begin
          m_drop = 1;
        end
      end else if (m_pend && rdy) begin
        m_pend = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic detect(input logic rdy);
    step(2'b10, 1'b0, rdy);
    step(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; state_in = 2'b00; clear = 1'b0; rpt_ready = 1'b0; clear_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rpt_valid !== 1'b0 || total !== '0) begin
      n_err++; $display("FAIL reset_in: rpt_valid=%0b total=%0d required 0/0", rpt_valid, total);
    end
    @(negedge clk); reset = 1'b1;
    repeat (5) step(2'b00, 1'b0, 1'b0);
    n_cmp++; if (hit_pulse !== 1'b0) begin n_err++; $display("FAIL idle_hit: got %0b required 0", hit_pulse); end
    n_cmp++; if (total !== '0)       begin n_err++; $display("FAIL idle_total: got %0d required 0", total); end
    n_cmp++; if (win_cnt !== '0)     begin n_err++; $display("FAIL idle_win: got %0d required 0", win_cnt); end
    n_cmp++; if (rpt_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %0b required 0", rpt_valid); end
    n_cmp++; if (rpt_data !== '0)    begin n_err++; $display("FAIL idle_data: got %0d required 0", rpt_data); end
    n_cmp++; if (rpt_drop !== 1'b0)  begin n_err++; $display("FAIL idle_drop: got %0b required 0", rpt_drop); end
  endtask

  task automatic test_single_detect();
    logic [1:0] seq [6];
    logic       exp_h [6];
    seq   = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    exp_h = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(seq[i], 1'b0, 1'b0);
      n_cmp++;
      if (hit_pulse !== exp_h[i]) begin
        n_err++; $display("FAIL single_hit[%0d]: got %0b required %0b", i, hit_pulse, exp_h[i]);
      end
    end
    n_cmp++; if (total !== 8'd1)     begin n_err++; $display("FAIL single_total: got %0d required 1", total); end
    n_cmp++; if (win_cnt !== 8'd1)   begin n_err++; $display("FAIL single_win: got %0d required 1", win_cnt); end
    n_cmp++; if (rpt_valid !== 1'b0) begin n_err++; $display("FAIL single_valid: got %0b required 0", rpt_valid); end
  endtask

  task automatic test_report_handshake();
    step(2'b00, 1'b1, 1'b0);
    repeat (4) detect(1'b0);
    n_cmp++; if (rpt_valid !== 1'b1) begin n_err++; $display("FAIL rpt_valid: got %0b required 1", rpt_valid); end
    n_cmp++; if (rpt_data !== 8'd4)  begin n_err++; $display("FAIL rpt_data: got %0d required 4", rpt_data); end
    n_cmp++; if (win_cnt !== 8'd0)   begin n_err++; $display("FAIL rpt_win: got %0d required 0", win_cnt); end
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b0, 1'b0);
      n_cmp++;
      if (rpt_valid !== 1'b1 || rpt_data !== 8'd4) begin
        n_err++; $display("FAIL rpt_hold[%0d]: valid=%0b data=%0d required 1/4", i, rpt_valid, rpt_data);
      end
    end
    step(2'b00, 1'b0, 1'b1);
    n_cmp++; if (rpt_valid !== 1'b0) begin n_err++; $display("FAIL rpt_accept: got %0b required 0", rpt_valid); end
  endtask

  task automatic test_drop_collision();
    step(2'b00, 1'b1, 1'b0);
    repeat (8) detect(1'b0);
    n_cmp++; if (rpt_data !== 8'd4)  begin n_err++; $display("FAIL drop_data: got %0d required 4", rpt_data); end
    n_cmp++; if (rpt_drop !== 1'b1)  begin n_err++; $display("FAIL drop_flag: got %0b required 1", rpt_drop); end
    n_cmp++; if (rpt_valid !== 1'b1) begin n_err++; $display("FAIL drop_valid: got %0b required 1", rpt_valid); end
    n_cmp++; if (total !== 8'd8)     begin n_err++; $display("FAIL drop_total: got %0d required 8", total); end
    step(2'b00, 1'b1, 1'b0);
    n_cmp++; if (rpt_drop !== 1'b0)  begin n_err++; $display("FAIL clear_drop: got %0b required 0", rpt_drop); end
    repeat (7) detect(1'b0);
    detect(1'b1);
    n_cmp++; if (rpt_valid !== 1'b1) begin n_err++; $display("FAIL coll_valid: got %0b required 1", rpt_valid); end
    n_cmp++; if (rpt_data !== 8'd8)  begin n_err++; $display("FAIL coll_data: got %0d required 8", rpt_data); end
    n_cmp++; if (rpt_drop !== 1'b0)  begin n_err++; $display("FAIL coll_drop: got %0b required 0", rpt_drop); end
  endtask

  task automatic test_clear_vs_hit();
    step(2'b00, 1'b1, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    n_cmp++; if (hit_pulse !== 1'b0) begin n_err++; $display("FAIL clrhit_pulse: got %0b required 0", hit_pulse); end
    n_cmp++; if (total !== 8'd0)     begin n_err++; $display("FAIL clrhit_total: got %0d required 0", total); end
    step(2'b10, 1'b0, 1'b0);
    n_cmp++; if (hit_pulse !== 1'b0 || total !== 8'd0) begin
      n_err++; $display("FAIL clrhit_held: pulse=%0b total=%0d required 0/0", hit_pulse, total);
    end
    step(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    step(2'b00, 1'b1, 1'b0);
    repeat (4) detect(1'b0);
    n_cmp++; if (rpt_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre: got %0b required 1", rpt_valid); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (rpt_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %0b required 0", rpt_valid); end
    n_cmp++; if (total !== 8'd0)     begin n_err++; $display("FAIL arst_total: got %0d required 0", total); end
    #2 reset = 1'b1;
    step(2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_saturate_wrap();
    int exp_b;
    clear_b = 1'b1;
    step(2'b00, 1'b0, 1'b0);
    clear_b = 1'b0;
    repeat (9) detect(1'b0);
`ifdef SEQ_CNT_WRAP_EN
    exp_b = 1;
`else
    exp_b = 7;
`endif
    n_cmp++; if (total_b !== WB'(exp_b)) begin n_err++; $display("FAIL sat_total: got %0d required %0d", total_b, exp_b); end
    n_cmp++; if (win_cnt_b !== 3'd2)     begin n_err++; $display("FAIL sat_win: got %0d required 2", win_cnt_b); end
    n_cmp++; if (rpt_valid_b !== 1'b1 || rpt_data_b !== 3'd7) begin
      n_err++; $display("FAIL sat_rpt: valid=%0b data=%0d required 1/7", rpt_valid_b, rpt_data_b);
    end
    n_cmp++; if (rpt_drop_b !== 1'b0 || hit_pulse_b !== 1'b0) begin
      n_err++; $display("FAIL sat_misc: drop=%0b pulse=%0b required 0/0", rpt_drop_b, hit_pulse_b);
    end
  endtask

  task automatic test_random();
    logic [1:0] st;
    logic       clr, rdy;
    step(2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      st  = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      step(st, clr, rdy);
      n_cmp++;
      if (hit_pulse !== m_hit) begin
        n_err++; $display("FAIL rnd_hit[%0d]: got %0b required %0b", i, hit_pulse, m_hit);
      end
      n_cmp++;
      if (total !== W'(exp_total(m_count))) begin
        n_err++; $display("FAIL rnd_total[%0d]: got %0d required %0d", i, total, exp_total(m_count));
      end
      n_cmp++;
      if (win_cnt !== W'(m_count % THRESH)) begin
        n_err++; $display("FAIL rnd_win[%0d]: got %0d required %0d", i, win_cnt, m_count % THRESH);
      end
      n_cmp++;
      if (rpt_valid !== m_pend) begin
        n_err++; $display("FAIL rnd_valid[%0d]: got %0b required %0b", i, rpt_valid, m_pend);
      end
      n_cmp++;
      if (rpt_data !== W'(m_data)) begin
        n_err++; $display("FAIL rnd_data[%0d]: got %0d required %0d", i, rpt_data, m_data);
      end
      n_cmp++;
      if (rpt_drop !== m_drop) begin
        n_err++; $display("FAIL rnd_drop[%0d]: got %0b required %0b", i, rpt_drop, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_detect();
    test_report_handshake();
    test_drop_collision();
    test_clear_vs_hit();
    test_async_reset();
    test_saturate_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_event_counter.md
Name: seq_event_counter

Overview:
- Downstream consumer of the 2-bit sequence-detector FSM; samples its `state_out` as `state_in`.
- Detects each entry into the detect state 2'b10 and emits a one-cycle hit pulse.
- Keeps a running total of detections.
- Every THRESH detections, offers a report (the running total) over a valid/ready handshake to a logger/host stage.

Parameters:
- CNT_W, 8, width of total counter and report data.
- THRESH, 4, detections per report window; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 resets all state immediately.
- state_in  input  2  detector state (00 idle, 01 one seen, 10 detect, 11 illegal).
- clear  input  1  synchronous clear of counters and pending report.
- hit_pulse  output  1  one-cycle pulse per detect entry.
- total  output  CNT_W  running detection count.
- win_cnt  output  CNT_W  detections in current window, 0..THRESH-1.
- rpt_valid  output  1  report available.
- rpt_ready  input  1  consumer accepts report.
- rpt_data  output  CNT_W  total captured at window completion.
- rpt_drop  output  1  sticky: a window completed while a report was pending.

Behaviour:
- Reset (reset=0, async): prev_state=00, hit_pulse=0, total=0, win_cnt=0, rpt_valid=0, rpt_data=0, rpt_drop=0, report FSM=R_IDLE. A pending report is discarded.
- Edge detect: hit = (state_in==2'b10) && (prev_state!=2'b10). prev_state <= state_in every cycle. 11 counts as not-detect.
- Latency: hit_pulse, total, win_cnt and report update on the same rising edge that samples hit. Outputs are visible one cycle after state_in first reads 10.
- Staying in 10 for several cycles yields one hit only.
- total: +1 per hit; saturates at 2^CNT_W-1, no further change.
- win_cnt: +1 per hit. A hit when win_cnt==THRESH-1 sets win_cnt to 0 and is a window completion. THRESH=1 makes every hit a completion.
- Report FSM states: R_IDLE and R_PEND.
  - R_IDLE, on completion: rpt_data <= updated total (including this hit), rpt_valid <= 1, go to R_PEND.
  - R_PEND: rpt_valid and rpt_data held stable while rpt_ready=0.
  - R_PEND with rpt_valid && rpt_ready at an edge: rpt_valid <= 0, go to R_IDLE.
  - R_PEND, completion and handshake on the same edge: the new report loads, rpt_valid stays 1, state stays R_PEND, no drop.
  - R_PEND, completion without handshake: report kept unchanged, rpt_drop <= 1 (sticky until clear/reset).
- clear=1 at an edge: total, win_cnt, rpt_valid, rpt_data, rpt_drop <= 0, FSM to R_IDLE, hit_pulse <= 0. A hit on the same edge is discarded. prev_state still updates, so a held 10 does not re-trigger after clear.
- rpt_ready while rpt_valid=0 has no effect.

Optional Feature:
- Macro: SEQ_CNT_WRAP_EN.
- Defined: total wraps from 2^CNT_W-1 to 0 on the next hit, and rpt_data follows the wrapped value.
- Undefined (default): total saturates as above.
- win_cnt and report behaviour are unaffected either way.

Decomposition:
- Package fsm_pkg holds:
  - detector state encodings S_IDLE=2'b00, S_ONE=2'b01, S_DET=2'b10, shared with the upstream detector;
  - report FSM encoding R_IDLE/R_PEND.
- One sub-module, seq_edge_det: registers prev_state and produces combinational hit. Reset to S_IDLE.
- Counters and report FSM stay in the top.

Test Plan:
- Reset and idle: reset=0 then 1, state_in=00 for 5 cycles -> all outputs 0.
- Single detection: state_in 00,01,10,10,10,00 -> exactly one hit_pulse, one cycle after first 10; total=1, win_cnt=1, rpt_valid=0.
- Report handshake: 4 detections, rpt_ready=0 -> rpt_valid=1, rpt_data=4, win_cnt=0, held stable 3 cycles; raise rpt_ready 1 cycle -> rpt_valid=0 next edge.
- Drop and collision: 8 detections with rpt_ready=0 -> rpt_data=4, rpt_drop=1. After clear, 4 detections, then a 5th-8th detection with rpt_ready=1 on the completing edge -> rpt_valid stays 1, rpt_data=8, rpt_drop=0.
- Clear vs hit and async reset: clear on the hit edge -> total=0, no hit_pulse. Reset asserted mid-R_PEND, between clock edges -> rpt_valid drops to 0 immediately.
- Saturation/wrap with CNT_W=3, THRESH=7: 9 hits -> total=7 without SEQ_CNT_WRAP_EN; total=1 with it.
